// File: rtl/riscv_pkg.sv
// Shared multicycle RISC-V control encodings: FSM state codes, opcodes and
// datapath mux/ALU select values used by both the control FSM and the datapath.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   typedef struct packed {
      logic       pc_update;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
   } ctrl_t;

endpackage

// File: rtl/fsm_outdec.sv
// Moore output decoder: maps the control FSM state to datapath control signals.
// Illegal state codes fall through to the all-zero default.
module fsm_outdec
   import riscv_pkg::*;
(
   input  state_t i_state,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.adr_src    = 1'b0;
            o_ctrl.ir_write   = 1'b1;
            o_ctrl.pc_update  = 1'b1;
            o_ctrl.alu_src_a  = SRCA_PC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            o_ctrl.alu_src_a = SRCA_OLDPC;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.result_src = RES_DATA;
            o_ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.adr_src    = 1'b1;
            o_ctrl.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_RS2;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a  = SRCA_RS1;
            o_ctrl.alu_src_b  = SRCB_RS2;
            o_ctrl.alu_op     = ALUOP_SUB;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.branch     = 1'b1;
         end
         // JAL writes OldPC+4 as the link value while ALUOut (target) loads the PC
         S_JAL: begin
            o_ctrl.alu_src_a  = SRCA_OLDPC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.pc_update  = 1'b1;
         end
         S_JALR: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_LUI: begin
            o_ctrl.alu_src_a = SRCA_ZERO;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_AUIPC: begin
            o_ctrl.alu_src_a = SRCA_OLDPC;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mainfsm.sv
// Multicycle RISC-V main control FSM: state register and next-state logic,
// with Moore outputs decoded by fsm_outdec.
module mainfsm
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   output logic       PCUpdate,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Branch,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [3:0] state
);

   state_t r_state;
   state_t w_next;
   ctrl_t  w_ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECUTER;
               OP_ITYPE:          w_next = S_EXECUTEI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI:            w_next = S_LUI;
               OP_AUIPC:          w_next = S_AUIPC;
               default:           w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JALR:     w_next = S_JAL;
         S_JAL:      w_next = S_ALUWB;
         S_LUI:      w_next = S_ALUWB;
         S_AUIPC:    w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   fsm_outdec u_outdec (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   // Reset parks the FSM in FETCH, whose IRWrite/PCUpdate must not leak out
   assign PCUpdate  = w_ctrl.pc_update & ~reset;
   assign IRWrite   = w_ctrl.ir_write  & ~reset;
   assign RegWrite  = w_ctrl.reg_write & ~reset;
   assign MemWrite  = w_ctrl.mem_write & ~reset;
   assign Branch    = w_ctrl.branch    & ~reset;
   assign AdrSrc    = w_ctrl.adr_src;
   assign ALUSrcA   = w_ctrl.alu_src_a;
   assign ALUSrcB   = w_ctrl.alu_src_b;
   assign ALUOp     = w_ctrl.alu_op;
   assign ResultSrc = w_ctrl.result_src;
   assign state     = r_state;

endmodule

// File: tb/tb_mainfsm.sv
// Directed table-driven bench for mainfsm: instruction state traces with
// per-state expected outputs, plus mid-instruction asynchronous reset sequences.
module tb_mainfsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic [3:0] state;

   mainfsm dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .PCUpdate  (PCUpdate),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .Branch    (Branch),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ResultSrc (ResultSrc),
      .state     (state)
   );

   always #5 clk = ~clk;

   // we = {PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc}
   typedef struct packed {
      logic [5:0] we;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] alu;
      logic [1:0] res;
   } exp_t;

   typedef struct {
      logic [6:0] op;
      logic [3:0] st;
   } vec_t;

   exp_t exp_tab [16];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [5:0] we_now();
      return {PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc};
   endfunction

   task automatic chk_state_outputs(input string tag, input logic [3:0] st);
      chk({tag, " state"}, 32'(state), 32'(st));
      chk({tag, " we"}, 32'(we_now()), 32'(exp_tab[st].we));
      chk({tag, " ALUSrcA"}, 32'(ALUSrcA), 32'(exp_tab[st].a));
      chk({tag, " ALUSrcB"}, 32'(ALUSrcB), 32'(exp_tab[st].b));
      chk({tag, " ALUOp"}, 32'(ALUOp), 32'(exp_tab[st].alu));
      chk({tag, " ResultSrc"}, 32'(ResultSrc), 32'(exp_tab[st].res));
   endtask

   task automatic add(input logic [6:0] o, input logic [3:0] s);
      vec_t v;
      v.op = o;
      v.st = s;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse_check(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({tag, " rst state"}, 32'(state), 32'd0);
      chk({tag, " rst we"}, 32'({PCUpdate, IRWrite, RegWrite, MemWrite, Branch}), 32'd0);
      step();
      chk({tag, " rst hold state"}, 32'(state), 32'd0);
      chk({tag, " rst hold we"}, 32'({PCUpdate, IRWrite, RegWrite, MemWrite, Branch}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, " release fetch we"}, 32'(we_now()), 32'b110000);
   endtask

   initial begin
      for (int unsigned i = 0; i < 16; i++) exp_tab[i] = '0;
      exp_tab[0]  = '{6'b110000, 2'b00, 2'b10, 2'b00, 2'b10};
      exp_tab[1]  = '{6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
      exp_tab[2]  = '{6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
      exp_tab[3]  = '{6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
      exp_tab[4]  = '{6'b001000, 2'b00, 2'b00, 2'b00, 2'b01};
      exp_tab[5]  = '{6'b000101, 2'b00, 2'b00, 2'b00, 2'b00};
      exp_tab[6]  = '{6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
      exp_tab[7]  = '{6'b000000, 2'b10, 2'b01, 2'b10, 2'b00};
      exp_tab[8]  = '{6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
      exp_tab[9]  = '{6'b000010, 2'b10, 2'b00, 2'b01, 2'b00};
      exp_tab[10] = '{6'b100000, 2'b01, 2'b10, 2'b00, 2'b00};
      exp_tab[11] = '{6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
      exp_tab[12] = '{6'b000000, 2'b11, 2'b01, 2'b00, 2'b00};
      exp_tab[13] = '{6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};

      // lw: 5 cycles
      add(7'b0000011, 1); add(7'b0000011, 2); add(7'b0000011, 3); add(7'b0000011, 4); add(7'b0000011, 0);
      // sw: 4 cycles
      add(7'b0100011, 1); add(7'b0100011, 2); add(7'b0100011, 5); add(7'b0100011, 0);
      // R-type / I-type
      add(7'b0110011, 1); add(7'b0110011, 6); add(7'b0110011, 8); add(7'b0110011, 0);
      add(7'b0010011, 1); add(7'b0010011, 7); add(7'b0010011, 8); add(7'b0010011, 0);
      // branch: 3 cycles
      add(7'b1100011, 1); add(7'b1100011, 9); add(7'b1100011, 0);
      // jal / jalr
      add(7'b1101111, 1); add(7'b1101111, 10); add(7'b1101111, 8); add(7'b1101111, 0);
      add(7'b1100111, 1); add(7'b1100111, 11); add(7'b1100111, 10); add(7'b1100111, 8); add(7'b1100111, 0);
      // lui / auipc
      add(7'b0110111, 1); add(7'b0110111, 12); add(7'b0110111, 8); add(7'b0110111, 0);
      add(7'b0010111, 1); add(7'b0010111, 13); add(7'b0010111, 8); add(7'b0010111, 0);
      // illegal opcodes: 2 cycles, nop
      add(7'b1111111, 1); add(7'b1111111, 0);
      add(7'b0000000, 1); add(7'b0000000, 0);

      reset = 1'b1;
      op    = 7'b0000011;
      #12;
      chk("reset state", 32'(state), 32'd0);
      chk("reset we", 32'(we_now()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_state_outputs("post-reset", 4'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         op = vecs[i].op;
         step();
         chk_state_outputs($sformatf("vec%0d op=%b", i, vecs[i].op), vecs[i].st);
      end

      // reset asserted in MEMREAD
      op = 7'b0000011;
      repeat (3) step();
      chk("lw reach state3", 32'(state), 32'd3);
      reset_pulse_check("memread");
      step();
      chk("after release first edge state", 32'(state), 32'd1);

      // reset asserted in MEMWB while RegWrite is high
      repeat (3) step();
      chk("lw reach state4 RegWrite", 32'(we_now()), 32'b001000);
      reset_pulse_check("memwb");

      // reset asserted in MEMWRITE while MemWrite is high
      op = 7'b0100011;
      repeat (3) step();
      chk("sw reach state5 we", 32'(we_now()), 32'b000101);
      reset_pulse_check("memwrite");
      step();
      chk("sw after release state", 32'(state), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
